regfile_bus_master: RTL
=======================

Name: regfile_bus_master

Overview:
- Initiator side of the register-file bus: sequences single-cycle enable/read_write/register_select transactions toward the register-file slave.
- Accepts one high-level request at a time (READ, WRITE, MOVE, SWAP) over a valid/ready handshake.
- Returns a one-cycle response with the result data.
- Sits between the control unit / instruction decoder and the register file.

Parameters:
ADDR_W, 2, register_select width (register count = 2^ADDR_W)
DATA_W, 8, data bus width

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  master can accept a request
req_op  in  2  00 READ rs, 01 WRITE imm->rd, 10 MOVE rs->rd, 11 SWAP rs<->rd
req_rd  in  ADDR_W  destination / second register
req_rs  in  ADDR_W  source register
req_imm  in  DATA_W  immediate for WRITE
rsp_valid  out  1  one-cycle response pulse
rsp_data  out  DATA_W  response data, held until next response
busy  out  1  high whenever state != IDLE
register_enable  out  1  slave enable
read_write  out  1  1 = read, 0 = write
register_select  out  ADDR_W  slave register index
bus_wdata  out  DATA_W  to slave data_bus_in
bus_rdata  in  DATA_W  from slave data_bus_out

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0, including register_enable, read_write, register_select, bus_wdata, rsp_valid, rsp_data and busy.
- Reset mid-operation aborts the sequence: no rsp_valid and no further bus cycles. A partially completed SWAP is not rolled back.
- All bus outputs are registered.

Slave timing contract:
- The slave samples enable/read_write/select/wdata on a rising edge.
- Read data is registered in the slave and appears on bus_rdata only while read_write = 1.
- A read is therefore two cycles:
  - ISSUE: enable = 1, rw = 1, select = reg.
  - CAP: enable = 0, rw = 1, select held; the master samples bus_rdata at the end of CAP.
- A write is one cycle, WR: enable = 1, rw = 0, select = reg, wdata valid.
- Outside these states: enable = 0, rw = 0, wdata = 0.

Handshake:
- req_ready = 1 only in IDLE.
- A request is accepted on an edge with req_valid & req_ready; req_op/rd/rs/imm are latched at that edge.
- Inputs are ignored while busy.

States: IDLE, RA_ISSUE, RA_CAP, RB_ISSUE, RB_CAP, WR_A, WR_B.
- READ: IDLE -> RA_ISSUE(rs) -> RA_CAP -> IDLE.
  - rsp_data = rs value.
  - rsp_valid in cycle 3 after acceptance (acceptance edge = end of cycle 0).
- WRITE: IDLE -> WR_A(rd, imm) -> IDLE.
  - rsp_data = imm; rsp_valid in cycle 2.
- MOVE: IDLE -> RA_ISSUE(rs) -> RA_CAP -> WR_A(rd, captured A) -> IDLE.
  - rsp_data = A; rsp_valid in cycle 4.
- SWAP: IDLE -> RA_ISSUE(rs) -> RA_CAP -> RB_ISSUE(rd) -> RB_CAP -> WR_A(rd, A) -> WR_B(rs, B) -> IDLE.
  - rsp_data = B (old rd value); rsp_valid in cycle 7.

Response and back-to-back:
- rsp_valid is set on the edge leaving the final state, so it is high for exactly the first IDLE cycle.
- rsp_data updates on that same edge.
- A new request may be accepted in that same cycle (rsp_valid = 1 and req_ready = 1 together).

Boundary cases:
- MOVE/SWAP with rd == rs run the full sequence; register contents are unchanged, rsp_data = that value.
- Register indices wrap naturally within ADDR_W; no range error exists.
- No bus cycle ever has register_enable = 1 in two consecutive cycles except WR_A -> WR_B.

Test Plan:
- Reset mid-SWAP (assert rst_n = 0 during RB_CAP) -> all outputs 0 immediately, no rsp_valid; after release, req_ready = 1 next cycle.
- WRITE rd = 2, imm = 0xA5, then READ rs = 2 -> write bus cycle enable = 1, rw = 0, sel = 2, wdata = 0xA5; rsp_valid cycle 2 with 0xA5. Read returns rsp_data = 0xA5 in cycle 3; rw held 1 during RA_CAP.
- Preload r0 = 0x11, r1 = 0x22; MOVE rs = 0 -> rd = 3 -> rsp_data = 0x11 in cycle 4; subsequent READ r3 = 0x11.
- Preload r1 = 0x22, r2 = 0x33; SWAP rs = 1, rd = 2 -> rsp_data = 0x33 in cycle 7; READ r1 = 0x33, READ r2 = 0x22; WR_A/WR_B are consecutive enable cycles.
- Back-to-back: req_valid held high with WRITE r0 = 0x01 then READ r0 -> second request accepted in the cycle rsp_valid is high; read returns 0x01; busy never deasserts between requests except that single IDLE cycle.
- req_valid pulsed while busy with a different op -> ignored; bus activity and rsp_data match only the accepted request.

Source files
------------

// File: rtl/regfile_bus_master.sv
// Initiator for the register-file bus: turns one READ/WRITE/MOVE/SWAP request
// into the two-cycle read / one-cycle write sequences the slave expects and
// returns a one-cycle response carrying the result data.
module regfile_bus_master #(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_rd,
  input  logic [ADDR_W-1:0] req_rs,
  input  logic [DATA_W-1:0] req_imm,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              busy,
  output logic              register_enable,
  output logic              read_write,
  output logic [ADDR_W-1:0] register_select,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata
);

  typedef enum logic [1:0] {OP_READ, OP_WRITE, OP_MOVE, OP_SWAP} op_t;
  typedef enum logic [2:0] {IDLE, RA_ISSUE, RA_CAP, RB_ISSUE, RB_CAP, WR_A, WR_B} state_t;

  state_t              state, state_n;
  op_t                 op_q, op_e;
  logic [ADDR_W-1:0]   rd_q, rs_q, rd_e, rs_e;
  logic [DATA_W-1:0]   imm_q, imm_e;
  logic [DATA_W-1:0]   a_q, b_q, a_n, b_n;
  logic                accept;
  logic                en_n, rw_n, rsp_valid_n;
  logic [ADDR_W-1:0]   sel_n;
  logic [DATA_W-1:0]   wdata_n, rsp_data_n;

  assign accept = req_valid & req_ready;
  assign busy   = (state != IDLE);

  // Next state plus next-cycle bus/response values; bus outputs are decoded
  // from the next state and registered so they line up with that state.
  always_comb begin
    // In IDLE the request fields are latched on the same edge, so decode them directly.
    op_e  = op_q;
    rd_e  = rd_q;
    rs_e  = rs_q;
    imm_e = imm_q;
    if (state == IDLE) begin
      op_e  = op_t'(req_op);
      rd_e  = req_rd;
      rs_e  = req_rs;
      imm_e = req_imm;
    end
    // Captured operands become visible combinationally on the capture edge.
    a_n = (state == RA_CAP) ? bus_rdata : a_q;
    b_n = (state == RB_CAP) ? bus_rdata : b_q;

    state_n = state;
    case (state)
      IDLE:     if (accept) state_n = (op_e == OP_WRITE) ? WR_A : RA_ISSUE;
      RA_ISSUE: state_n = RA_CAP;
      RA_CAP: begin
        case (op_e)
          OP_READ: state_n = IDLE;
          OP_MOVE: state_n = WR_A;
          default: state_n = RB_ISSUE;
        endcase
      end
      RB_ISSUE: state_n = RB_CAP;
      RB_CAP:   state_n = WR_A;
      WR_A:     state_n = (op_e == OP_SWAP) ? WR_B : IDLE;
      WR_B:     state_n = IDLE;
      default:  state_n = IDLE;
    endcase

    en_n    = 1'b0;
    rw_n    = 1'b0;
    sel_n   = '0;
    wdata_n = '0;
    case (state_n)
      RA_ISSUE: begin en_n = 1'b1; rw_n = 1'b1; sel_n = rs_e; end
      RA_CAP:   begin rw_n = 1'b1; sel_n = rs_e; end
      RB_ISSUE: begin en_n = 1'b1; rw_n = 1'b1; sel_n = rd_e; end
      RB_CAP:   begin rw_n = 1'b1; sel_n = rd_e; end
      WR_A: begin
        en_n    = 1'b1;
        sel_n   = rd_e;
        wdata_n = (op_e == OP_WRITE) ? imm_e : a_n;
      end
      WR_B: begin en_n = 1'b1; sel_n = rs_e; wdata_n = b_n; end
      default: ;
    endcase

    rsp_valid_n = (state != IDLE) && (state_n == IDLE);
    rsp_data_n  = rsp_data;
    if (rsp_valid_n) begin
      case (op_e)
        OP_WRITE: rsp_data_n = imm_e;
        OP_SWAP:  rsp_data_n = b_n;
        default:  rsp_data_n = a_n;
      endcase
    end
  end

  // State, latched request, captured operands and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      req_ready       <= 1'b0;
      op_q            <= OP_READ;
      rd_q            <= '0;
      rs_q            <= '0;
      imm_q           <= '0;
      a_q             <= '0;
      b_q             <= '0;
      register_enable <= 1'b0;
      read_write      <= 1'b0;
      register_select <= '0;
      bus_wdata       <= '0;
      rsp_valid       <= 1'b0;
      rsp_data        <= '0;
    end else begin
      state           <= state_n;
      req_ready       <= (state_n == IDLE);
      if (accept) begin
        op_q  <= op_e;
        rd_q  <= rd_e;
        rs_q  <= rs_e;
        imm_q <= imm_e;
      end
      a_q             <= a_n;
      b_q             <= b_n;
      register_enable <= en_n;
      read_write      <= rw_n;
      register_select <= sel_n;
      bus_wdata       <= wdata_n;
      rsp_valid       <= rsp_valid_n;
      rsp_data        <= rsp_data_n;
    end
  end

endmodule
